// File: rtl/dmem_access_ctrl_if.sv
// Bundle of request, response and banked-memory signals for the data-memory
// access controller. The controller takes the slave view; whoever issues the
// requests and models the memory takes the master view.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 13,
    parameter int NBANK  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rw;
    logic [NBANK-1:0]  mem_en;
    logic [7:0]        mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_rw, mem_en
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_rw, mem_en
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller. A 32-bit load is assembled from four single
// byte reads on consecutive cycles (little-endian, bank chosen per byte from
// the top address bits, address wrapping modulo 2^ADDR_W). A store is issued
// as one write cycle to the bank of the base address. Each operation ends in
// a response held until the consumer accepts it.
module dmem_access_ctrl #(
    parameter int ADDR_W = 13,
    parameter int NBANK  = 8
) (
    input logic              clk,
    input logic              reset,
    dmem_access_ctrl_if.slave bus
);

    localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_addr;
    logic [2:0]        k;
    logic [ADDR_W-1:0] next_addr;
    logic [1:0]        cap_idx;
    logic              accept;

    // One-hot enable for the bank that owns a byte address.
    function automatic logic [NBANK-1:0] bank_onehot(input logic [ADDR_W-1:0] addr);
        logic [NBANK-1:0] oh;
        oh = '0;
        oh[addr[ADDR_W-1 -: BANK_W]] = 1'b1;
        return oh;
    endfunction

    // Address of the next read issue; natural truncation gives the wrap.
    assign next_addr = base_addr + ADDR_W'(k) + ADDR_W'(1);

    // While k counts 1..4 the byte arriving on mem_rdata belongs to issue k-1.
    assign cap_idx = k[1:0] - 2'd1;

    assign accept = bus.req_valid && bus.req_ready;

    // Single state machine: sequences issues, captures bytes and drives all
    // outputs from registers so the memory sees glitch-free controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            base_addr     <= '0;
            k             <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_rw    <= 1'b1;
            bus.mem_en    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    bus.mem_en    <= '0;
                    bus.mem_rw    <= 1'b1;
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        base_addr     <= bus.req_addr;
                        bus.mem_addr  <= bus.req_addr;
                        bus.mem_en    <= bank_onehot(bus.req_addr);
                        bus.rsp_rdata <= '0;
                        k             <= '0;
                        if (bus.req_we) begin
                            state         <= WR;
                            bus.mem_wdata <= bus.req_wdata;
                            bus.mem_rw    <= 1'b0;
                        end else begin
                            state      <= RD;
                            bus.mem_rw <= 1'b1;
                        end
                    end
                end

                RD: begin
                    k <= k + 3'd1;
                    if (k != 3'd0) begin
                        bus.rsp_rdata[{cap_idx, 3'b000} +: 8] <= bus.mem_rdata;
                    end
                    if (k < 3'd3) begin
                        bus.mem_addr <= next_addr;
                        bus.mem_en   <= bank_onehot(next_addr);
                    end else begin
                        bus.mem_en <= '0;
                    end
                    if (k == 3'd4) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        k             <= '0;
                    end
                end

                WR: begin
                    bus.mem_en    <= '0;
                    bus.mem_rw    <= 1'b1;
                    bus.rsp_rdata <= '0;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                    bus.mem_en    <= '0;
                    bus.mem_rw    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 13: byte address width on both the request side and the memory side.
REQ-002 Parameter NBANK, default 8: number of memory banks; bank select = mem_addr[ADDR_W-1 -: log2(NBANK)].
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port req_valid, input, 1: request present.
REQ-006 Port req_ready, output, 1: controller can accept a request.
REQ-007 Port req_we, input, 1: 1 = store word, 0 = load word.
REQ-008 Port req_addr, input, ADDR_W: byte address.
REQ-009 Port req_wdata, input, 32: store data.
REQ-010 Port rsp_valid, output, 1: response present.
REQ-011 Port rsp_ready, input, 1: consumer accepts the response.
REQ-012 Port rsp_rdata, output, 32: assembled load data.
REQ-013 Port mem_addr, output, ADDR_W: byte address to the banked memory.
REQ-014 Port mem_wdata, output, 32: write data to memory.
REQ-015 Port mem_rw, output, 1: 1 = read, 0 = write.
REQ-016 Port mem_en, output, NBANK: one-hot bank enable.
REQ-017 Port mem_rdata, input, 8: byte returned by the enabled bank, valid exactly 1 cycle after a read issue.

Function
REQ-018 States: IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-019 Handshake: a request is accepted on an edge with req_valid && req_ready; req_addr, req_we and req_wdata are latched at that edge.
REQ-020 IDLE -> RD on an accepted load; IDLE -> WR on an accepted store.
REQ-021 RD: issue 4 reads on consecutive cycles with k = 0..3; mem_addr = base + k modulo 2^ADDR_W; mem_rw = 1.
REQ-022 RD capture: the byte for issue k is captured from mem_rdata on the cycle after the issue into rsp_rdata[8k+7:8k] (little-endian); the capture of byte 3 occurs in the cycle after the last issue, with mem_en = 0 in that cycle.
REQ-023 RD -> RESP after the byte-3 capture; the load response appears 6 cycles after the accept edge (rsp_valid high in cycle 6).
REQ-024 Misaligned bases are legal; bytes crossing a bank boundary use the bank decoded from each byte's own mem_addr.
REQ-025 WR: one cycle with mem_addr = base, mem_wdata = req_wdata, mem_rw = 0 and mem_en one-hot for the base's bank; then -> RESP. A store response returns rsp_rdata = 0.
REQ-026 mem_en is 0 in IDLE and RESP and is never more than one-hot.
REQ-027 mem_rw is 1 whenever no write is being issued.
REQ-028 RESP: rsp_valid is held with stable rsp_rdata until rsp_ready; RESP -> IDLE on rsp_valid && rsp_ready.
REQ-029 Back-to-back requests: no request is accepted in the same cycle as a response handshake; minimum spacing is response handshake -> IDLE -> accept.
REQ-030 req_valid is ignored outside IDLE; req_* changes after acceptance have no effect.

Reset
REQ-031 While reset = 0, all state clears asynchronously: state = IDLE, k = 0, rsp_rdata = 0, rsp_valid = 0, mem_en = 0, mem_rw = 1, mem_addr = 0, mem_wdata = 0, req_ready = 0.
REQ-032 req_ready rises in the first cycle after reset deasserts.
REQ-033 Reset mid-read or mid-write aborts the operation, produces no response and retains no partial data.

Verification
REQ-034 Aligned load, base 0x0404 with memory bytes 11,22,33,44 -> mem_en = 8'b0000_0010 on all 4 issues; rsp_rdata = 0x44332211 with rsp_valid in cycle 6.
REQ-035 Bank-crossing load, base 0x03FE -> issue addresses 0x3FE, 0x3FF, 0x400, 0x401 with mem_en = 0x01, 0x01, 0x02, 0x02; bytes assembled in that order.
REQ-036 Wrap load, base 0x1FFF -> addresses 0x1FFF, 0x0000, 0x0001, 0x0002 with mem_en = 0x80, 0x01, 0x01, 0x01.
REQ-037 Store 0xDEADBEEF to 0x1C00 -> exactly one cycle with mem_rw = 0, mem_en = 0x80, mem_wdata = 0xDEADBEEF; then rsp_valid with rsp_rdata = 0.
REQ-038 rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stay stable, req_ready stays 0, and a new req_valid is not accepted.
REQ-039 reset asserted during the 3rd read issue -> all outputs take their reset values immediately; after release, a new load to 0x0000 completes normally.
